// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, DATA_W data bits (LSB first), optional parity, 1-2 stop bits.
// Bit timing comes from a clock-enable bit timer in the clk domain; the next frame may be accepted in the last stop cycle.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | line high, ready for a word
//  S_START | start bit (low) for D cycles
//  S_DATA  | data bits, shreg[0] on the line, shift right after each bit
//  S_PAR   | parity bit (never entered when PARITY = 0)
//  S_STOP  | stop bit(s), high; last cycle may accept the next word
module uart_tx_cfg #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  localparam logic [3:0] BIT_LAST  = 4'(DATA_W - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_t              state, state_n;
  logic [DIV_W-1:0]    timer, timer_n;
  logic [DIV_W-1:0]    div_q, div_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                par_q, par_n;
  logic [3:0]          bit_cnt, bit_n;
  logic                stop_cnt, stop_n;
  logic                tx_n;
  logic                last_tick;
  logic                last_stop;
  logic                accept;

  assign last_tick = (timer == div_q);
  assign last_stop = (state == S_STOP) && last_tick && (stop_cnt == STOP_LAST);
  assign tx_ready  = (state == S_IDLE) || last_stop;
  assign busy      = (state != S_IDLE);
  assign accept    = tx_valid && tx_ready;

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    div_n   = div_q;
    shreg_n = shreg;
    par_n   = par_q;
    bit_n   = bit_cnt;
    stop_n  = stop_cnt;

    case (state)
      S_IDLE: timer_n = '0;
      S_START: begin
        if (last_tick) begin
          timer_n = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (last_tick) begin
          timer_n = '0;
          shreg_n = shreg >> 1;
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            stop_n  = 1'b0;
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (last_tick) begin
          timer_n = '0;
          stop_n  = 1'b0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (last_tick) begin
          timer_n = '0;
          if (stop_cnt == STOP_LAST) state_n = S_IDLE;
          else                       stop_n  = stop_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A handshake (idle or last stop cycle) overrides the above and starts a fresh frame
    if (accept) begin
      state_n = S_START;
      timer_n = '0;
      div_n   = baud_div;
      shreg_n = tx_data;
      par_n   = (PARITY == 1) ? ~^tx_data : ^tx_data;
    end

    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shreg_n[0];
      S_PAR:   tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      div_q    <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      div_q    <= div_n;
      shreg    <= shreg_n;
      par_q    <= par_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances cover 8N1, 7O2 and 8E1 frame formats.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] bd0, bd1, bd2;
  logic [7:0]  d0, d2;
  logic [6:0]  d1;
  logic        v0, v1, v2;
  logic        r0, r1, r2;
  logic        tx0, tx1, tx2;
  logic        b0, b1, b2;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic tx_m, rdy_m, busy_m;
  assign tx_m   = (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
  assign rdy_m  = (sel == 0) ? r0  : (sel == 1) ? r1  : r2;
  assign busy_m = (sel == 0) ? b0  : (sel == 1) ? b1  : b2;

  uart_tx_cfg #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) dut0 (
    .clk(clk), .rst(rst), .baud_div(bd0), .tx_data(d0), .tx_valid(v0),
    .tx_ready(r0), .tx(tx0), .busy(b0));

  uart_tx_cfg #(.DATA_W(7), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) dut1 (
    .clk(clk), .rst(rst), .baud_div(bd1), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .tx(tx1), .busy(b1));

  uart_tx_cfg #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) dut2 (
    .clk(clk), .rst(rst), .baud_div(bd2), .tx_data(d2), .tx_valid(v2),
    .tx_ready(r2), .tx(tx2), .busy(b2));

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL rst_tx0 got %b want 1", tx0); end
    n_checks++; if (r0  !== 1'b1) begin n_fail++; $display("FAIL rst_rdy0 got %b want 1", r0); end
    n_checks++; if (b0  !== 1'b0) begin n_fail++; $display("FAIL rst_busy0 got %b want 0", b0); end
    n_checks++; if (tx1 !== 1'b1) begin n_fail++; $display("FAIL rst_tx1 got %b want 1", tx1); end
    n_checks++; if (r1  !== 1'b1) begin n_fail++; $display("FAIL rst_rdy1 got %b want 1", r1); end
    n_checks++; if (b1  !== 1'b0) begin n_fail++; $display("FAIL rst_busy1 got %b want 0", b1); end
    n_checks++; if (tx2 !== 1'b1) begin n_fail++; $display("FAIL rst_tx2 got %b want 1", tx2); end
    n_checks++; if (r2  !== 1'b1) begin n_fail++; $display("FAIL rst_rdy2 got %b want 1", r2); end
    n_checks++; if (b2  !== 1'b0) begin n_fail++; $display("FAIL rst_busy2 got %b want 0", b2); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (tx0 !== 1'b1 || r0 !== 1'b1 || b0 !== 1'b0)
      begin n_fail++; $display("FAIL post_rst_idle got tx=%b rdy=%b busy=%b want 1 1 0", tx0, r0, b0); end
  endtask

  // 0xA5, 8N1, baud_div=3: start, 1,0,1,0,0,1,0,1, stop (bit index 0 = start)
  task automatic test_8n1();
    logic [9:0] exp = 10'b1101001010;
    sel = 0;
    @(negedge clk); bd0 = 16'd3; d0 = 8'hA5; v0 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); v0 = 1'b0;
      n_checks++; if (tx_m !== exp[k/4]) begin n_fail++; $display("FAIL t8n1_tx k=%0d got %b want %b", k, tx_m, exp[k/4]); end
      n_checks++; if (rdy_m !== 1'(k == 39)) begin n_fail++; $display("FAIL t8n1_rdy k=%0d got %b want %b", k, rdy_m, (k == 39)); end
      n_checks++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL t8n1_busy k=%0d got %b want 1", k, busy_m); end
    end
    @(negedge clk);
    n_checks++; if (tx_m !== 1'b1 || rdy_m !== 1'b1 || busy_m !== 1'b0)
      begin n_fail++; $display("FAIL t8n1_idle got tx=%b rdy=%b busy=%b want 1 1 0", tx_m, rdy_m, busy_m); end
  endtask

  // 7'h03, odd parity, 2 stops, 1 clk per bit: 0,1,1,0,0,0,0,0,1,1,1
  task automatic test_7o2();
    logic [10:0] exp = 11'b11100000110;
    sel = 1;
    @(negedge clk); bd1 = 16'd0; d1 = 7'h03; v1 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk); v1 = 1'b0;
      n_checks++; if (tx_m !== exp[k]) begin n_fail++; $display("FAIL t7o2_tx k=%0d got %b want %b", k, tx_m, exp[k]); end
      n_checks++; if (rdy_m !== 1'(k == 10)) begin n_fail++; $display("FAIL t7o2_rdy k=%0d got %b want %b", k, rdy_m, (k == 10)); end
      n_checks++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL t7o2_busy k=%0d got %b want 1", k, busy_m); end
    end
    @(negedge clk);
    n_checks++; if (tx_m !== 1'b1 || busy_m !== 1'b0)
      begin n_fail++; $display("FAIL t7o2_idle got tx=%b busy=%b want 1 0", tx_m, busy_m); end
  endtask

  // 0xFF then 0x00, even parity, baud_div=1, valid held: no gap between frames
  task automatic test_back_to_back();
    logic [10:0] exp1 = 11'b10111111110;
    logic [10:0] exp2 = 11'b10000000000;
    logic        want;
    sel = 2;
    @(negedge clk); bd2 = 16'd1; d2 = 8'hFF; v2 = 1'b1;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k == 0)  d2 = 8'h00;
      if (k == 22) v2 = 1'b0;
      want = (k < 22) ? exp1[k/2] : exp2[(k-22)/2];
      n_checks++; if (tx_m !== want) begin n_fail++; $display("FAIL tb2b_tx k=%0d got %b want %b", k, tx_m, want); end
      n_checks++; if (rdy_m !== 1'(k == 21 || k == 43)) begin n_fail++; $display("FAIL tb2b_rdy k=%0d got %b want %b", k, rdy_m, (k == 21 || k == 43)); end
      n_checks++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL tb2b_busy k=%0d got %b want 1", k, busy_m); end
    end
    @(negedge clk);
    n_checks++; if (tx_m !== 1'b1 || busy_m !== 1'b0)
      begin n_fail++; $display("FAIL tb2b_idle got tx=%b busy=%b want 1 0", tx_m, busy_m); end
  endtask

  // Async reset mid-DATA of 0x5A, then a full clean 0x5A frame
  task automatic test_reset_mid_frame();
    logic [9:0] exp = 10'b1010110100;
    sel = 0;
    @(negedge clk); bd0 = 16'd3; d0 = 8'h5A; v0 = 1'b1;
    for (int k = 0; k <= 10; k++) begin @(negedge clk); v0 = 1'b0; end
    n_checks++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL trst_pre_busy got %b want 1", busy_m); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL trst_tx got %b want 1", tx0); end
    n_checks++; if (r0  !== 1'b1) begin n_fail++; $display("FAIL trst_rdy got %b want 1", r0); end
    n_checks++; if (b0  !== 1'b0) begin n_fail++; $display("FAIL trst_busy got %b want 0", b0); end
    @(negedge clk); rst = 1'b0; d0 = 8'h5A; v0 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); v0 = 1'b0;
      n_checks++; if (tx_m !== exp[k/4]) begin n_fail++; $display("FAIL trst_tx k=%0d got %b want %b", k, tx_m, exp[k/4]); end
      n_checks++; if (rdy_m !== 1'(k == 39)) begin n_fail++; $display("FAIL trst_rdy k=%0d got %b want %b", k, rdy_m, (k == 39)); end
    end
    @(negedge clk);
  endtask

  // baud_div 3->9 and tx_data changed mid-frame; next frame 0x0F at 10 clk per bit
  task automatic test_param_latch();
    logic [9:0] exp1 = 10'b1101001010;
    logic [9:0] exp2 = 10'b1000011110;
    sel = 0;
    @(negedge clk); bd0 = 16'd3; d0 = 8'hA5; v0 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      v0 = 1'b0;
      if (k == 5) begin bd0 = 16'd9; d0 = 8'h00; end
      n_checks++; if (tx_m !== exp1[k/4]) begin n_fail++; $display("FAIL tlat1_tx k=%0d got %b want %b", k, tx_m, exp1[k/4]); end
    end
    @(negedge clk);
    n_checks++; if (rdy_m !== 1'b1 || busy_m !== 1'b0)
      begin n_fail++; $display("FAIL tlat_gap got rdy=%b busy=%b want 1 0", rdy_m, busy_m); end
    d0 = 8'h0F; v0 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); v0 = 1'b0;
      n_checks++; if (tx_m !== exp2[k/10]) begin n_fail++; $display("FAIL tlat2_tx k=%0d got %b want %b", k, tx_m, exp2[k/10]); end
      n_checks++; if (rdy_m !== 1'(k == 99)) begin n_fail++; $display("FAIL tlat2_rdy k=%0d got %b want %b", k, rdy_m, (k == 99)); end
    end
    @(negedge clk);
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL tlat2_idle busy got %b want 0", busy_m); end
  endtask

  // 0x33 at baud_div=1 with valid pulses mid-frame that must be ignored
  task automatic test_valid_while_busy();
    logic [9:0] exp = 10'b1001100110;
    sel = 0;
    @(negedge clk); bd0 = 16'd1; d0 = 8'h33; v0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      v0 = (k == 3 || k == 4 || k == 5 || k == 15);
      if (v0) d0 = 8'hFF;
      n_checks++; if (tx_m !== exp[k/2]) begin n_fail++; $display("FAIL tvb_tx k=%0d got %b want %b", k, tx_m, exp[k/2]); end
      n_checks++; if (rdy_m !== 1'(k == 19)) begin n_fail++; $display("FAIL tvb_rdy k=%0d got %b want %b", k, rdy_m, (k == 19)); end
    end
    @(negedge clk);
    n_checks++; if (busy_m !== 1'b0 || tx_m !== 1'b1)
      begin n_fail++; $display("FAIL tvb_idle got busy=%b tx=%b want 0 1", busy_m, tx_m); end
  endtask

  initial begin
    bd0 = '0; bd1 = '0; bd2 = '0;
    d0 = '0; d1 = '0; d2 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    test_reset();
    test_8n1();
    test_7o2();
    test_back_to_back();
    test_reset_mid_frame();
    test_param_latch();
    test_valid_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
